// File: rtl/fly_hit_detector.sv
// Bullet-versus-fly collision scanner: one fly slot tested per cycle.
// Reports the lowest-index hit with a kill pulse and keeps a saturating score.
module fly_hit_detector #(
  parameter int N_FLY   = 17,
  parameter int FLY_W   = 32,
  parameter int FLY_H   = 32,
  parameter int BUL_W   = 4,
  parameter int BUL_H   = 8,
  parameter int SCORE_W = 16
) (
  input  logic                  clk25,
  input  logic                  reset_n,
  input  logic [10*N_FLY-1:0]   fly_x_flat,
  input  logic [10*N_FLY-1:0]   fly_y_flat,
  input  logic [N_FLY-1:0]      fly_alive_flat,
  input  logic [9:0]            bullet_x,
  input  logic [9:0]            bullet_y,
  input  logic                  bullet_req,
  input  logic                  score_clr,
  output logic                  busy,
  output logic                  bullet_ack,
  output logic                  hit_valid,
  output logic [4:0]            hit_index,
  output logic [N_FLY-1:0]      kill_mask,
  output logic [SCORE_W-1:0]    score,
  output logic                  all_clear
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT_HIT,
    REPORT_MISS
  } state_t;

  localparam logic [10:0] L_BW = 11'(BUL_W - 1);
  localparam logic [10:0] L_BH = 11'(BUL_H - 1);
  localparam logic [10:0] L_FW = 11'(FLY_W - 1);
  localparam logic [10:0] L_FH = 11'(FLY_H - 1);
  localparam logic [4:0]  L_LAST = 5'(N_FLY - 1);
  localparam logic [SCORE_W-1:0] L_SMAX = '1;
  localparam logic [N_FLY-1:0] L_ONE = N_FLY'(1);

  state_t               r_state;
  state_t               w_next;
  logic [4:0]           r_idx;
  logic [9:0]           r_bx;
  logic [9:0]           r_by;
  logic                 r_busy;
  logic                 r_ack;
  logic                 r_hv;
  logic [4:0]           r_hidx;
  logic [N_FLY-1:0]     r_kill;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_allc;

  logic [9:0]           w_fx;
  logic [9:0]           w_fy;
  logic                 w_alive;
  logic                 w_hit;
  logic                 w_last;
  logic [N_FLY-1:0]     w_kill;

  // Overlap test of the current slot against the latched bullet, 11-bit sums.
  always_comb begin
    w_fx    = fly_x_flat[r_idx*10 +: 10];
    w_fy    = fly_y_flat[r_idx*10 +: 10];
    w_alive = fly_alive_flat[r_idx];
    w_hit   = w_alive
            && ({1'b0, w_fx} <= {1'b0, r_bx} + L_BW)
            && ({1'b0, r_bx} <= {1'b0, w_fx} + L_FW)
            && ({1'b0, w_fy} <= {1'b0, r_by} + L_BH)
            && ({1'b0, r_by} <= {1'b0, w_fy} + L_FH);
    w_last  = (r_idx == L_LAST);
    w_kill  = L_ONE << r_idx;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (bullet_req) w_next = SCAN;
      SCAN: begin
        if (w_hit)       w_next = REPORT_HIT;
        else if (w_last) w_next = REPORT_MISS;
      end
      REPORT_HIT:  w_next = IDLE;
      REPORT_MISS: w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Bullet latch, scan index and registered report outputs.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= '0;
      r_bx   <= '0;
      r_by   <= '0;
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
      r_hv   <= 1'b0;
      r_hidx <= '0;
      r_kill <= '0;
    end else begin
      if (r_state == IDLE && bullet_req) begin
        r_bx  <= bullet_x;
        r_by  <= bullet_y;
        r_idx <= '0;
      end else if (r_state == SCAN && !w_hit && !w_last) begin
        r_idx <= r_idx + 5'd1;
      end
      r_busy <= (w_next != IDLE);
      r_ack  <= (w_next == REPORT_HIT) || (w_next == REPORT_MISS);
      r_hv   <= (w_next == REPORT_HIT);
      r_kill <= (w_next == REPORT_HIT) ? w_kill : '0;
      if (w_next == REPORT_HIT) r_hidx <= r_idx;
    end
  end

  // Saturating hit counter; clear wins over a same-edge hit.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_score <= '0;
    end else if (score_clr) begin
      r_score <= '0;
    end else if (r_state == SCAN && w_hit && r_score != L_SMAX) begin
      r_score <= r_score + 1'b1;
    end
  end

  // Registered "every fly dead" flag.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) r_allc <= 1'b0;
    else          r_allc <= ~|fly_alive_flat;
  end

  assign busy       = r_busy;
  assign bullet_ack = r_ack;
  assign hit_valid  = r_hv;
  assign hit_index  = r_hidx;
  assign kill_mask  = r_kill;
  assign score      = r_score;
  assign all_clear  = r_allc;

endmodule

// File: tb/tb_fly_hit_detector.sv
// Directed bench for fly_hit_detector with a geometric reference model.
// Model predicts each test from rectangle overlap of alive flies.
module tb_fly_hit_detector;

  localparam int N = 17;

  logic              clk25 = 1'b0;
  logic              reset_n = 1'b1;
  logic [10*N-1:0]   fly_x_flat;
  logic [10*N-1:0]   fly_y_flat;
  logic [N-1:0]      fly_alive_flat;
  logic [9:0]        bullet_x = '0;
  logic [9:0]        bullet_y = '0;
  logic              bullet_req = 1'b0;
  logic              score_clr = 1'b0;
  logic              busy;
  logic              bullet_ack;
  logic              hit_valid;
  logic [4:0]        hit_index;
  logic [N-1:0]      kill_mask;
  logic [15:0]       score;
  logic              all_clear;

  int                fx [N];
  int                fy [N];
  logic [N-1:0]      alive = '1;
  logic              preset = 1'b0;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          m_c0 = 0;
  int          m_end = -100;
  int          m_k = 0;
  logic        m_hit = 1'b0;
  logic [15:0] m_score = '0;
  logic [4:0]  m_hidx = '0;
  logic        m_allc = 1'b0;

  fly_hit_detector dut (
    .clk25(clk25),
    .reset_n(reset_n),
    .fly_x_flat(fly_x_flat),
    .fly_y_flat(fly_y_flat),
    .fly_alive_flat(fly_alive_flat),
    .bullet_x(bullet_x),
    .bullet_y(bullet_y),
    .bullet_req(bullet_req),
    .score_clr(score_clr),
    .busy(busy),
    .bullet_ack(bullet_ack),
    .hit_valid(hit_valid),
    .hit_index(hit_index),
    .kill_mask(kill_mask),
    .score(score),
    .all_clear(all_clear)
  );

  always #5 clk25 = ~clk25;

  always_comb begin
    fly_x_flat = '0;
    fly_y_flat = '0;
    for (int i = 0; i < N; i++) begin
      fly_x_flat[i*10 +: 10] = 10'(fx[i]);
      fly_y_flat[i*10 +: 10] = 10'(fy[i]);
    end
    fly_alive_flat = alive;
  end

  function automatic int first_hit(int bx, int by);
    for (int i = 0; i < N; i++) begin
      if (alive[i] && fx[i] <= bx + 3 && bx <= fx[i] + 31 &&
          fy[i] <= by + 7 && by <= fy[i] + 31)
        return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_c0 = 0;
    m_end = -100;
    m_hit = 1'b0;
    m_score = '0;
    m_hidx = '0;
    m_allc = 1'b0;
  endtask

  task automatic model_update();
    cyc++;
    m_allc = ~|alive;
    if (preset) m_score = 16'hFFFF;
    if (bullet_req && cyc >= m_end + 2) begin
      m_c0  = cyc;
      m_k   = first_hit(int'(bullet_x), int'(bullet_y));
      m_hit = (m_k >= 0);
      m_end = cyc + (m_hit ? m_k + 1 : N);
    end
    if (cyc == m_end && m_hit) m_hidx = 5'(m_k);
    if (score_clr) m_score = '0;
    else if (cyc == m_end && m_hit && m_score != 16'hFFFF)
      m_score = m_score + 16'd1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    logic e_ack;
    logic [N-1:0] e_kill;
    e_ack  = reset_n && (cyc == m_end);
    e_kill = (e_ack && m_hit) ? (N'(1) << m_k) : '0;
    chk("busy", 32'(busy), 32'(reset_n && cyc >= m_c0 && cyc <= m_end));
    chk("bullet_ack", 32'(bullet_ack), 32'(e_ack));
    chk("hit_valid", 32'(hit_valid), 32'(e_ack && m_hit));
    chk("kill_mask", 32'(kill_mask), 32'(e_kill));
    chk("hit_index", 32'(hit_index), 32'(m_hidx));
    chk("score", 32'(score), 32'(m_score));
    chk("all_clear", 32'(all_clear), 32'(m_allc));
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk25);
      if (reset_n) model_update();
      @(negedge clk25);
      compare_all();
    end
  endtask

  task automatic set_row();
    for (int i = 0; i < N; i++) begin
      fx[i] = i * 38;
      fy[i] = 0;
    end
    alive = '1;
  endtask

  // Pulse a request, then count cycles until the ack (bounded).
  task automatic shoot(int bx, int by, output int lat);
    bullet_x = 10'(bx);
    bullet_y = 10'(by);
    bullet_req = 1'b1;
    step(1);
    bullet_req = 1'b0;
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (!bullet_ack && lat < 40);
  endtask

  int lat;
  int acks;

  initial begin
    set_row();
    #1 reset_n = 1'b0;
    model_reset();
    step(3);
    reset_n = 1'b1;
    step(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_score", 32'(score), 0);

    shoot(120, 20, lat);
    chk("hit3_lat", 32'(lat), 4);
    chk("hit3_valid", 32'(hit_valid), 1);
    chk("hit3_index", 32'(hit_index), 3);
    chk("hit3_kill", 32'(kill_mask), 32'h00008);
    chk("hit3_score", 32'(score), 1);
    step(2);

    fx[1] = 20;
    shoot(28, 10, lat);
    chk("ovl_lat", 32'(lat), 1);
    chk("ovl_index", 32'(hit_index), 0);
    chk("ovl_kill", 32'(kill_mask), 32'h00001);
    step(2);
    set_row();

    shoot(600, 400, lat);
    chk("miss_lat", 32'(lat), 17);
    chk("miss_valid", 32'(hit_valid), 0);
    chk("miss_kill", 32'(kill_mask), 0);
    chk("miss_score", 32'(score), 2);
    step(2);

    alive[3] = 1'b0;
    step(1);
    shoot(120, 20, lat);
    chk("dead_lat", 32'(lat), 17);
    chk("dead_valid", 32'(hit_valid), 0);
    step(2);
    set_row();

    shoot(107, 31, lat);
    chk("edge_lat", 32'(lat), 3);
    chk("edge_index", 32'(hit_index), 2);
    step(2);
    shoot(110, 0, lat);
    chk("gap_lat", 32'(lat), 17);
    step(2);

    fy[0] = 1000;
    shoot(0, 1020, lat);
    chk("ywide_lat", 32'(lat), 1);
    chk("ywide_valid", 32'(hit_valid), 1);
    step(2);
    set_row();

    bullet_x = 10'd120;
    bullet_y = 10'd20;
    bullet_req = 1'b1;
    step(1);
    bullet_req = 1'b0;
    bullet_x = 10'd0;
    bullet_y = 10'd0;
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (!bullet_ack && lat < 40);
    chk("latch_lat", 32'(lat), 4);
    chk("latch_index", 32'(hit_index), 3);
    step(2);

    bullet_x = 10'd600;
    bullet_y = 10'd400;
    bullet_req = 1'b1;
    step(1);
    bullet_req = 1'b0;
    step(2);
    bullet_req = 1'b1;
    step(1);
    bullet_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (bullet_ack) acks++;
    end
    chk("ignore_acks", 32'(acks), 1);

    force dut.r_score = 16'hFFFF;
    preset = 1'b1;
    #1 release dut.r_score;
    step(1);
    preset = 1'b0;
    shoot(120, 20, lat);
    chk("sat_valid", 32'(hit_valid), 1);
    chk("sat_score", 32'(score), 32'hFFFF);
    step(2);

    score_clr = 1'b1;
    shoot(120, 20, lat);
    chk("clr_lat", 32'(lat), 4);
    chk("clr_score", 32'(score), 0);
    score_clr = 1'b0;
    step(2);
    shoot(0, 0, lat);
    chk("post_clr", 32'(score), 1);
    step(2);

    bullet_x = 10'd600;
    bullet_y = 10'd400;
    bullet_req = 1'b1;
    step(1);
    bullet_req = 1'b0;
    step(4);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ack", 32'(bullet_ack), 0);
    chk("arst_score", 32'(score), 0);
    chk("arst_allc", 32'(all_clear), 0);
    alive = '0;
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("allc", 32'(all_clear), 1);
    shoot(120, 20, lat);
    chk("fresh_lat", 32'(lat), 17);
    chk("fresh_valid", 32'(hit_valid), 0);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
